ifetch_prefetch: RTL

- Instruction fetch stage directly upstream of the multi-cycle processor's Decode state.
- Reads 16-bit instruction words from instruction memory over a req/ack handshake and buffers them with their PC in a small prefetch FIFO.
- Presents words to decode over a valid/ready handshake.
- Handles PC redirects from jumps/traps (flush plus squash of in-flight fetch) and stops fetching on halt.

---
 rtl/ifetch_prefetch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch.sv
// ============================================================================
// Module   : ifetch_prefetch
// Brief    : Instruction fetch with req/ack memory port and prefetch FIFO
//            feeding decode over valid/ready; supports redirect and halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNTW     = 3
) (
    input  logic            clk,
    input  logic            reset,
    output logic            o_imem_req,
    output logic [15:0]     o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [15:0]     i_imem_rdata,
    output logic            o_ir_valid,
    output logic [15:0]     o_ir,
    output logic [15:0]     o_ir_pc,
    input  logic            i_ir_ready,
    input  logic            i_redirect,
    input  logic [15:0]     i_redirect_pc,
    input  logic            i_halt,
    output logic [CNTW-1:0] o_fifo_count
);

    localparam int              c_ptrw  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW-1:0] c_depth = CNTW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    state_t            r_state;
    logic [15:0]       r_fetch_pc;
    logic              r_req;
    logic [15:0]       r_addr;
    logic [15:0]       r_mem_ir [DEPTH];
    logic [15:0]       r_mem_pc [DEPTH];
    logic [c_ptrw-1:0] r_rd_ptr;
    logic [c_ptrw-1:0] r_wr_ptr;
    logic [CNTW-1:0]   r_count;
    logic              r_ir_valid;
    logic [15:0]       r_ir;
    logic [15:0]       r_ir_pc;

    logic              w_push;
    logic              w_pop;
    logic [CNTW-1:0]   w_count_next;
    logic              w_can_issue;
    logic [c_ptrw-1:0] w_rd_next;
    logic              w_head_fwd;
    logic [15:0]       w_head_ir;
    logic [15:0]       w_head_pc;
    logic [15:0]       w_pc_inc;

    // A redirect voids both the push and the pop of its cycle.
    assign w_push       = (r_state == S_WAIT) && i_imem_ack && !i_redirect;
    assign w_pop        = (r_count != '0) && i_ir_ready && !i_redirect;
    assign w_count_next = r_count + CNTW'(w_push) - CNTW'(w_pop);
    assign w_can_issue  = !i_halt && !i_redirect && (w_count_next < c_depth);
    assign w_pc_inc     = r_fetch_pc + 16'd1;

    // The new head is either already stored or is the word arriving now.
    assign w_rd_next  = r_rd_ptr + c_ptrw'(w_pop);
    assign w_head_fwd = w_push && (r_wr_ptr == w_rd_next);
    assign w_head_ir  = w_head_fwd ? i_imem_rdata : r_mem_ir[w_rd_next];
    assign w_head_pc  = w_head_fwd ? r_fetch_pc   : r_mem_pc[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ir[r_wr_ptr] <= i_imem_rdata;
            r_mem_pc[r_wr_ptr] <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ir_valid <= 1'b0;
            r_ir       <= 16'h0000;
            r_ir_pc    <= 16'h0000;
        end else begin
            if (i_redirect) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_ir_valid <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptrw'(1);
                end
                r_rd_ptr   <= w_rd_next;
                r_count    <= w_count_next;
                r_ir_valid <= (w_count_next != '0);
                if (w_count_next != '0) begin
                    r_ir    <= w_head_ir;
                    r_ir_pc <= w_head_pc;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (i_redirect) begin
                        r_fetch_pc <= i_redirect_pc;
                    end else if (w_can_issue) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (i_redirect) begin
                        r_fetch_pc <= i_redirect_pc;
                        if (i_imem_ack) begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= S_SQUASH;
                        end
                    end else if (i_imem_ack) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_can_issue) begin
                            r_addr <= w_pc_inc;
                        end else begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                S_SQUASH: begin
                    // Stale request must still complete before a new one issues.
                    if (i_redirect) begin
                        r_fetch_pc <= i_redirect_pc;
                    end else if (i_imem_ack) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req   = r_req;
    assign o_imem_addr  = r_addr;
    assign o_ir_valid   = r_ir_valid;
    assign o_ir         = r_ir;
    assign o_ir_pc      = r_ir_pc;
    assign o_fifo_count = r_count;

endmodule

`default_nettype wire
